attack_sequencer: RTL and testbench
===================================

# attack_sequencer

Executes the attack a fighter has been cleared to perform. It is the consumer side of the attack_enable / attack_busy handshake with player_state. On an enabled request it latches which attack was pressed, then steps through startup, active and recovery phases counted in SCEN frame ticks. It drives attack_busy back to player_state and drives hitbox/phase information to the collision resolver and sprite logic. A hitstun from game_resolver aborts any attack in progress.

## Interface
Parameters:
- CNT_W, 6, width of the phase frame counter; all phase lengths must be in 1..2^CNT_W-1
- A1_STARTUP, 3, attack1 startup length in SCEN ticks
- A1_ACTIVE, 2, attack1 active (hitbox) length in SCEN ticks
- A1_RECOVERY, 4, attack1 recovery length in SCEN ticks
- A2_STARTUP, 6, attack2 startup length in SCEN ticks
- A2_ACTIVE, 3, attack2 active length in SCEN ticks
- A2_RECOVERY, 8, attack2 recovery length in SCEN ticks

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- SCEN  in  1  frame-tick enable, one clk wide; all state advances only on clk edges with SCEN=1
- attack_enable  in  1  start grant from player_state
- attack1  in  1  attack1 button level
- attack2  in  1  attack2 button level
- hitstun_active  in  1  abort request from game_resolver
- attack_busy  out  1  high whenever state ≠ IDLE
- attack_id  out  2  01 = attack1, 10 = attack2, 00 in IDLE
- attack_phase  out  2  0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
- hitbox_active  out  1  high only in ACTIVE
- attack_done  out  1  one-clk pulse on normal completion
- attack_aborted  out  1  one-clk pulse when hitstun cancels an attack

## Operation
- FSM states: IDLE, STARTUP, ACTIVE, RECOVERY. A down-counter cnt[CNT_W-1:0] times each phase.
- Request latch (req_sel): on every SCEN tick in IDLE, if attack1=1 then req_sel←attack1; else if attack2=1 then req_sel←attack2; otherwise hold. Reset value is attack1.
- Start condition: in IDLE with SCEN=1, attack_enable=1 and hitstun_active=0, go to STARTUP. The attack type comes from the buttons on that tick using the same priority (attack1 over attack2). If neither button is pressed, use req_sel. Load cnt with startup length − 1.
- In STARTUP, ACTIVE or RECOVERY on a SCEN tick:
  - If cnt ≠ 0, decrement cnt.
  - If cnt = 0, advance to the next phase and load that phase's length − 1.
  - From RECOVERY with cnt = 0, go to IDLE and pulse attack_done.
- Each phase therefore lasts exactly its parameter value in SCEN ticks.
- Hitstun priority: on a SCEN tick with hitstun_active=1:
  - From any non-IDLE state: go to IDLE, clear cnt, pulse attack_aborted. No attack_done pulse.
  - In IDLE: a start is blocked even if attack_enable=1.
- attack_enable is ignored outside IDLE.
- Returning to IDLE with a button still held is allowed to retrigger on a later enable. No cooldown is added here.
- All outputs are registered. attack_id and the phase parameters are frozen for the whole attack; changing buttons mid-attack has no effect.

## Timing
- Reset (reset=0, asynchronous), all outputs and state:
  - state IDLE, cnt 0, req_sel attack1
  - attack_busy 0, attack_id 00, attack_phase 0, hitbox_active 0, attack_done 0, attack_aborted 0
- Release is synchronous to clk through the existing reset synchroniser.
- Start latency: attack_busy, attack_phase=1 and attack_id go valid on the same clk edge as the SCEN tick that samples attack_enable=1.
- Handshake with player_state: player_state sees busy=0 on the start tick and may keep attack_enable high one more tick. The sequencer is already in STARTUP then and ignores it. No double start occurs.
- Attack duration: attack_busy stays high for exactly STARTUP+ACTIVE+RECOVERY SCEN ticks.
- attack_done and attack_aborted are high for one clk cycle, the one following the SCEN edge that causes the transition. They are never both high.
- Reset mid-attack forces IDLE immediately; no pulse is generated.
- SCEN=0: all state and outputs hold; pulses still clear after one clk.

## Test plan
- Attack1 basic: enable at SCEN tick T with attack1=1 → attack_id=01; phase=1 for ticks T..T+2, phase=2 (hitbox 1) after T+3 through T+4, phase=3 after T+5 through T+8; IDLE after T+9 with attack_done pulse; busy high for 9 ticks.
- Attack2 and priority: attack1=attack2=1 at enable → attack_id=01. attack2 only → attack_id=10, busy for 17 ticks, hitbox for 3 ticks.
- Hitstun abort: hitstun_active=1 on the 2nd ACTIVE tick of attack1 → next edge IDLE, hitbox 0, busy 0, attack_aborted pulse, no attack_done. Hitstun with attack_enable=1 in IDLE → no start.
- Handshake overlap: attack_enable held 2 ticks from T → single attack; phase counts are unchanged by the second enable.
- SCEN gating: SCEN held 0 for 50 clk mid-STARTUP → phase and cnt frozen; duration in SCEN ticks unchanged.
- Async reset mid-RECOVERY: assert reset=0 between clk edges → all outputs 0 immediately; after release, a new enable starts cleanly.

Source files
------------

// File: rtl/attack_sequencer.sv
// Runs one granted attack through the STARTUP, ACTIVE and RECOVERY phases, each timed in SCEN frame ticks.
// Latency: outputs are registered and change on the clk edge of the SCEN tick that starts, advances or aborts the attack.
// Backpressure: attack_busy holds player_state off, and attack_enable is ignored until the sequencer is back in IDLE.
//
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   SCEN                : one-clk frame-tick enable; all state advances only on SCEN
//   attack_enable       : start grant from player_state
//   attack1, attack2    : button levels (attack1 has priority)
//   hitstun_active      : abort request from game_resolver
//   attack_busy         : high whenever not IDLE
//   attack_id           : 01 attack1, 10 attack2, 00 idle
//   attack_phase        : 0 idle, 1 startup, 2 active, 3 recovery
//   hitbox_active       : high only in ACTIVE
//   attack_done         : one-clk pulse on normal completion
//   attack_aborted      : one-clk pulse when hitstun cancels an attack
module attack_sequencer #(
  parameter int CNT_W       = 6,
  parameter int A1_STARTUP  = 3,
  parameter int A1_ACTIVE   = 2,
  parameter int A1_RECOVERY = 4,
  parameter int A2_STARTUP  = 6,
  parameter int A2_ACTIVE   = 3,
  parameter int A2_RECOVERY = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       attack_enable,
  input  logic       attack1,
  input  logic       attack2,
  input  logic       hitstun_active,
  output logic       attack_busy,
  output logic [1:0] attack_id,
  output logic [1:0] attack_phase,
  output logic       hitbox_active,
  output logic       attack_done,
  output logic       attack_aborted
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTUP  = 2'd1,
    ACTIVE   = 2'd2,
    RECOVERY = 2'd3
  } state_t;

  // The counter holds (phase length - 1) so a phase ends on the tick it reads zero.
  localparam logic [CNT_W-1:0] A1_S_M1 = CNT_W'(A1_STARTUP - 1);
  localparam logic [CNT_W-1:0] A1_A_M1 = CNT_W'(A1_ACTIVE - 1);
  localparam logic [CNT_W-1:0] A1_R_M1 = CNT_W'(A1_RECOVERY - 1);
  localparam logic [CNT_W-1:0] A2_S_M1 = CNT_W'(A2_STARTUP - 1);
  localparam logic [CNT_W-1:0] A2_A_M1 = CNT_W'(A2_ACTIVE - 1);
  localparam logic [CNT_W-1:0] A2_R_M1 = CNT_W'(A2_RECOVERY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_sel, req_sel_nxt;   // 0 = attack1, 1 = attack2
  logic             start_sel;
  logic [1:0]       id_nxt;
  logic             done_nxt, aborted_nxt;
  logic             busy_nxt, hitbox_nxt;
  logic [1:0]       phase_nxt;

  function automatic logic [CNT_W-1:0] len_m1(input logic sel2, input state_t ph);
    case (ph)
      STARTUP: return sel2 ? A2_S_M1 : A1_S_M1;
      ACTIVE:  return sel2 ? A2_A_M1 : A1_A_M1;
      default: return sel2 ? A2_R_M1 : A1_R_M1;
    endcase
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      req_sel        <= 1'b0;
      attack_busy    <= 1'b0;
      attack_id      <= 2'b00;
      attack_phase   <= 2'd0;
      hitbox_active  <= 1'b0;
      attack_done    <= 1'b0;
      attack_aborted <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      req_sel        <= req_sel_nxt;
      attack_busy    <= busy_nxt;
      attack_id      <= id_nxt;
      attack_phase   <= phase_nxt;
      hitbox_active  <= hitbox_nxt;
      attack_done    <= done_nxt;
      attack_aborted <= aborted_nxt;
    end
  end

  // Next state; attack_id doubles as the frozen attack selector for the whole attack
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_sel_nxt = req_sel;
    id_nxt      = attack_id;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    start_sel   = attack1 ? 1'b0 : (attack2 ? 1'b1 : req_sel);
    if (SCEN) begin
      if (state == IDLE) begin
        if (attack1)      req_sel_nxt = 1'b0;
        else if (attack2) req_sel_nxt = 1'b1;
        if (attack_enable && !hitstun_active) begin
          state_nxt = STARTUP;
          id_nxt    = start_sel ? 2'b10 : 2'b01;
          cnt_nxt   = len_m1(start_sel, STARTUP);
        end
      end else if (hitstun_active) begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        id_nxt      = 2'b00;
        aborted_nxt = 1'b1;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
      end else begin
        case (state)
          STARTUP: begin
            state_nxt = ACTIVE;
            cnt_nxt   = len_m1(attack_id[1], ACTIVE);
          end
          ACTIVE: begin
            state_nxt = RECOVERY;
            cnt_nxt   = len_m1(attack_id[1], RECOVERY);
          end
          default: begin
            state_nxt = IDLE;
            id_nxt    = 2'b00;
            done_nxt  = 1'b1;
          end
        endcase
      end
    end
  end

  // Output decode from the next state so every output lands in a register
  always_comb begin
    busy_nxt   = (state_nxt != IDLE);
    phase_nxt  = state_nxt;
    hitbox_nxt = (state_nxt == ACTIVE);
  end

endmodule

// File: tb/tb_attack_sequencer.sv
module tb_attack_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SCEN = 1'b0;
  logic       attack_enable = 1'b0;
  logic       attack1 = 1'b0;
  logic       attack2 = 1'b0;
  logic       hitstun_active = 1'b0;
  logic       attack_busy;
  logic [1:0] attack_id;
  logic [1:0] attack_phase;
  logic       hitbox_active;
  logic       attack_done;
  logic       attack_aborted;

  attack_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .SCEN           (SCEN),
    .attack_enable  (attack_enable),
    .attack1        (attack1),
    .attack2        (attack2),
    .hitstun_active (hitstun_active),
    .attack_busy    (attack_busy),
    .attack_id      (attack_id),
    .attack_phase   (attack_phase),
    .hitbox_active  (hitbox_active),
    .attack_done    (attack_done),
    .attack_aborted (attack_aborted)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // expected {busy, id[1:0], phase[1:0], hitbox, done, aborted} after a posedge
  logic [7:0] exp_q[$];

  // Reference model: an attack is "ticks elapsed since start" against phase lengths
  int m_busy = 0, m_id = 0, m_el = 0, m_req = 1;
  int m_s = 0, m_a = 0, m_r = 0;

  function automatic logic [7:0] pack_exp(int busy, int id, int el, int s, int a, int done, int ab);
    int ph;
    ph = 0;
    if (busy != 0) ph = (el < s) ? 1 : ((el < s + a) ? 2 : 3);
    return {busy[0], id[1:0], ph[1:0], (ph == 2) ? 1'b1 : 1'b0, done[0], ab[0]};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {attack_busy, attack_id, attack_phase, hitbox_active, attack_done, attack_aborted};
  endfunction

  task automatic check_direct(input string name, input logic [7:0] want);
    logic [7:0] got;
    got = dut_vec();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  // One clk cycle of stimulus: drive at negedge, advance the model, queue expectation
  task automatic cyc(input bit scen, input bit en, input bit a1, input bit a2, input bit hs);
    int done, ab, sel;
    @(negedge clk);
    reset          = 1'b1;
    SCEN           = scen;
    attack_enable  = en;
    attack1        = a1;
    attack2        = a2;
    hitstun_active = hs;
    done = 0;
    ab   = 0;
    if (scen) begin
      if (m_busy == 0) begin
        sel = a1 ? 1 : (a2 ? 2 : m_req);
        if (a1) m_req = 1;
        else if (a2) m_req = 2;
        if (en && !hs) begin
          m_busy = 1;
          m_id   = sel;
          m_el   = 0;
          m_s = (sel == 1) ? 3 : 6;
          m_a = (sel == 1) ? 2 : 3;
          m_r = (sel == 1) ? 4 : 8;
        end
      end else if (hs) begin
        m_busy = 0;
        m_id   = 0;
        ab     = 1;
      end else begin
        m_el++;
        if (m_el == m_s + m_a + m_r) begin
          m_busy = 0;
          m_id   = 0;
          done   = 1;
        end
      end
    end
    exp_q.push_back(pack_exp(m_busy, m_id, m_el, m_s, m_a, done, ab));
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge
  task automatic mid_reset();
    @(negedge clk);
    SCEN = 1'b0;
    attack_enable = 1'b0;
    #2 reset = 1'b0;
    #1 check_direct("async_reset", 8'h00);
    m_busy = 0;
    m_id   = 0;
    m_el   = 0;
    m_req  = 1;
    exp_q.push_back(8'h00);
  endtask

  // Monitor: compare every queued expectation just after the edge it belongs to
  initial begin
    logic [7:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_vec();
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got busy/id/phase/hit/done/abort=%b required=%b", $time, g, e);
        end
      end
    end
  end

  initial begin
    #3 check_direct("reset_state", 8'h00);

    // attack1 basic, SCEN every clk
    cyc(1, 1, 1, 0, 0);
    repeat (11) cyc(1, 0, 0, 0, 0);
    // both buttons: attack1 wins
    cyc(1, 1, 1, 1, 0);
    repeat (11) cyc(1, 0, 0, 0, 0);
    // attack2 only, SCEN every other clk
    cyc(1, 1, 0, 1, 0);
    repeat (40) begin
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
    end
    // req_sel latch: press attack2 alone, later enable with no button
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0, 0);
    // hitstun on 2nd ACTIVE tick of attack1
    cyc(1, 1, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    // hitstun in IDLE blocks a start
    cyc(1, 1, 1, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    // enable held two ticks: single attack
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    repeat (12) cyc(1, 0, 0, 0, 0);
    // SCEN stall of 50 clk mid-STARTUP
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (50) cyc(0, 1, 1, 0, 0);
    repeat (20) cyc(1, 0, 0, 0, 0);
    // async reset mid-RECOVERY, then a clean restart
    cyc(1, 1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 0);
    mid_reset();
    cyc(1, 1, 0, 1, 0);
    repeat (20) cyc(1, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) mid_reset();
      else cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 24) == 0);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
